adder_full: RTL and testbench

ADDER_FULL -- requirements
Module: adder_full

---
 rtl/adder_full.sv | 32 +++
 tb/tb_adder_full.sv | 110 +++++++++++
 2 files changed

// File: rtl/adder_full.sv
// adder_full: 1-bit full adder with combinational sum/carry and registered copies.
// The combinational path has no dependence on clk or rst_n.
module adder_full (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out,
  output logic sum_r,
  output logic c_out_r
);
  logic sum_d, c_out_d, sum_q, c_out_q;
  always_comb begin
    sum_d   = a ^ b ^ c_in;
    c_out_d = (a & b) | (a & c_in) | (b & c_in);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end
  assign sum     = sum_d;
  assign c_out   = c_out_d;
  assign sum_r   = sum_q;
  assign c_out_r = c_out_q;
endmodule

// File: tb/tb_adder_full.sv
// tb_adder_full: directed table-driven checks of the full adder, plus reset and
// register-timing sequences.
module tb_adder_full;
  logic clk = 1'b0;
  logic rst_n, a, b, c_in;
  logic sum, c_out, sum_r, c_out_r;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic       c;
    logic [1:0] exp;
  } vec_t;
  vec_t v [8];
  logic [1:0] exp_tab [8];
  logic [1:0] prev;

  adder_full dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
    .sum(sum), .c_out(c_out), .sum_r(sum_r), .c_out_r(c_out_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ai, input logic bi, input logic ci);
    a = ai;
    b = bi;
    c_in = ci;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v[i].a   = i[0];
      v[i].b   = i[1];
      v[i].c   = i[2];
      v[i].exp = exp_tab[i];
    end
    // Reset asserted with all inputs high: comb path live, registers cleared.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    #3;
    check("rst_comb", {c_out, sum}, 2'b11);
    check("rst_regs", {c_out_r, sum_r}, 2'b00);
    @(negedge clk);
    check("rst_regs_after_edge", {c_out_r, sum_r}, 2'b00);
    // Combinational sweep, registers held in reset.
    for (int i = 0; i < 8; i++) begin
      drive(v[i].a, v[i].b, v[i].c);
      #1;
      check($sformatf("comb_%0d", i), {c_out, sum}, v[i].exp);
      #9;
      check($sformatf("comb_hold_%0d", i), {c_out, sum}, v[i].exp);
    end
    // Release reset with a=b=0, c_in=1.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", {c_out_r, sum_r}, 2'b00);
    @(negedge clk);
    check("release_first_edge", {c_out_r, sum_r}, 2'b01);
    // a=1,b=0,c_in=1: registers hold until the next edge.
    drive(1'b1, 1'b0, 1'b1);
    #1;
    check("hold_before_edge", {c_out_r, sum_r}, 2'b01);
    check("comb_101", {c_out, sum}, 2'b10);
    @(negedge clk);
    check("load_101", {c_out_r, sum_r}, 2'b10);
    // Get sum_r=1, then drop reset between edges.
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("load_001", {c_out_r, sum_r}, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", {c_out_r, sum_r}, 2'b00);
    check("async_comb", {c_out, sum}, 2'b01);
    // Clocked sweep, one vector per cycle.
    @(negedge clk);
    rst_n = 1'b1;
    prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      drive(v[i].a, v[i].b, v[i].c);
      #1;
      check($sformatf("reg_hold_%0d", i), {c_out_r, sum_r}, prev);
      @(negedge clk);
      check($sformatf("reg_load_%0d", i), {c_out_r, sum_r}, v[i].exp);
      prev = v[i].exp;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
